// File: rtl/circuito_pwm.sv
// circuito_pwm: fixed-period PWM generator with four selectable pulse widths.
// The selected width is sampled only at the period boundary. A pulse that is
// already in progress therefore keeps the width it started with.
module circuito_pwm #(
  parameter int unsigned conf_periodo = 1000000,
  parameter int unsigned largura_00   = 0,
  parameter int unsigned largura_01   = 50000,
  parameter int unsigned largura_10   = 75000,
  parameter int unsigned largura_11   = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] largura,
  output logic       pwm,
  output logic       db_pwm
);

  localparam int unsigned     CNT_W    = (conf_periodo > 1) ? $clog2(conf_periodo) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(conf_periodo - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      largura_sel;
  logic [31:0]      largura_ativa;
  logic [31:0]      largura_ativa_next;
  logic             fim_periodo;
  logic             pwm_next;

  // Width selector: map the 2-bit code to its compile-time high-time.
  always_comb begin
    // NOTE: assign a default before the case so that no path leaves the
    // signal unassigned; otherwise synthesis infers a latch.
    largura_sel = largura_00;
    case (largura)
      2'b00:   largura_sel = largura_00;
      2'b01:   largura_sel = largura_01;
      2'b10:   largura_sel = largura_10;
      default: largura_sel = largura_11;
    endcase
  end

  // Next-state logic: wrap the counter at the end of the period and reload
  // the shadow width on that same edge. The output is compared against the
  // post-edge values, so the pulse begins on the edge where cnt becomes 0.
  always_comb begin
    fim_periodo        = (cnt == CNT_LAST);
    cnt_next           = fim_periodo ? '0 : cnt + CNT_W'(1);
    largura_ativa_next = fim_periodo ? largura_sel : largura_ativa;
    pwm_next           = (32'(cnt_next) < largura_ativa_next);
  end

  // State registers: the counter, the shadow width and the registered output.
  // Reset clears the width, which keeps the first period after reset low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      largura_ativa <= '0;
      pwm           <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments for all sequential state. Every
      // register then updates from the pre-edge values, whatever the
      // statement order.
      cnt           <= cnt_next;
      largura_ativa <= largura_ativa_next;
      pwm           <= pwm_next;
    end
  end

  // The debug output is the same register, so it cannot diverge from pwm.
  assign db_pwm = pwm;

endmodule

// File: tb/tb_circuito_pwm.sv
// tb_circuito_pwm: directed test of circuito_pwm with a 1250-cycle period.
// dut_a uses the nominal widths 0/50/500/1000. dut_b covers the edge cases:
// widths 0, 1, equal to the period (1250) and longer than the period (1300).
module tb_circuito_pwm;

  localparam int PER = 1250;

  logic       clock;
  logic       reset;
  logic [1:0] largura_a;
  logic [1:0] largura_b;
  logic       pwm_a;
  logic       db_a;
  logic       pwm_b;
  logic       db_b;

  int vectors     = 0;
  int miscompares = 0;
  int k           = 0;  // rising edges since the last reset release
  int seq         = 0;  // index of the period-check call, used in tags

  circuito_pwm #(
    .conf_periodo(PER), .largura_00(0), .largura_01(50),
    .largura_10(500),   .largura_11(1000)
  ) dut_a (
    .clock(clock), .reset(reset), .largura(largura_a),
    .pwm(pwm_a), .db_pwm(db_a)
  );

  circuito_pwm #(
    .conf_periodo(PER), .largura_00(0), .largura_01(1),
    .largura_10(1250),  .largura_11(1300)
  ) dut_b (
    .clock(clock), .reset(reset), .largura(largura_b),
    .pwm(pwm_b), .db_pwm(db_b)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    k++;
  endtask

  // Run n cycles from the current phase and check every sample against the
  // widths the bench expects for this period (w_a, w_b). The cN_at/cN_val
  // pairs change largura_a right after the sample at that phase. Use -1 for
  // an unused pair.
  task automatic run_period(input int n, input int w_a, input int w_b,
                            input int c0_at, input int c0_val,
                            input int c1_at, input int c1_val,
                            input int c2_at, input int c2_val);
    int   e_pa  = 0;
    int   e_da  = 0;
    int   e_pb  = 0;
    int   e_db  = 0;
    int   e_cnt = 0;
    int   hi_a  = 0;
    int   hi_b  = 0;
    int   p;
    logic exp_a;
    logic exp_b;
    logic [31:0] cnt_obs;
    for (int i = 0; i < n; i++) begin
      p       = k % PER;
      exp_a   = (p < w_a);
      exp_b   = (p < w_b);
      cnt_obs = 32'(dut_a.cnt);
      if (pwm_a !== exp_a) e_pa++;
      if (db_a  !== exp_a) e_da++;
      if (pwm_b !== exp_b) e_pb++;
      if (db_b  !== exp_b) e_db++;
      if (cnt_obs !== 32'(p)) e_cnt++;
      if (pwm_a === 1'b1) hi_a++;
      if (pwm_b === 1'b1) hi_b++;
      if (p == PER - 1) check($sformatf("c%0d cnt_last", seq), cnt_obs, 32'(PER - 1));
      if (p == c0_at) largura_a = 2'(c0_val);
      if (p == c1_at) largura_a = 2'(c1_val);
      if (p == c2_at) largura_a = 2'(c2_val);
      step();
    end
    if (k % PER == 0) check($sformatf("c%0d cnt_wrap", seq), 32'(dut_a.cnt), 32'd0);
    check($sformatf("c%0d pwm_a cycle errors", seq), e_pa, 0);
    check($sformatf("c%0d db_a cycle errors", seq), e_da, 0);
    check($sformatf("c%0d pwm_b cycle errors", seq), e_pb, 0);
    check($sformatf("c%0d db_b cycle errors", seq), e_db, 0);
    check($sformatf("c%0d cnt errors", seq), e_cnt, 0);
    if (n == PER) begin
      check($sformatf("c%0d high_a", seq), hi_a, w_a);
      check($sformatf("c%0d high_b", seq), hi_b, (w_b < PER) ? w_b : PER);
    end
    seq++;
  endtask

  initial begin
    reset     = 1'b1;
    largura_a = 2'b00;
    largura_b = 2'b10;
    #5 reset  = 1'b0;
    #1;
    check("async reset pwm_a", pwm_a, 0);
    check("async reset db_a", db_a, 0);
    check("async reset cnt", 32'(dut_a.cnt), 0);
    step();
    check("reset hold cnt", 32'(dut_a.cnt), 0);
    check("reset hold pwm_b", pwm_b, 0);
    @(negedge clock);
    reset = 1'b1;
    k     = 0;

    // The first period is low even though dut_b already selects 1250.
    run_period(PER, 0, 0,     -1, 0, -1, 0, -1, 0);
    largura_b = 2'b11;
    run_period(PER, 0, 1250,  -1, 0, -1, 0, -1, 0);
    largura_a = 2'b01;
    largura_b = 2'b01;
    run_period(PER, 0, 1300,  -1, 0, -1, 0, -1, 0);
    run_period(PER, 50, 1,    -1, 0, -1, 0, -1, 0);
    // Switch to 500 cycles in the middle of the 50-cycle pulse.
    run_period(PER, 50, 1,    20, 2, -1, 0, -1, 0);
    // Switch to 1000 cycles in the middle of the 500-cycle pulse.
    run_period(PER, 500, 1,   300, 3, -1, 0, -1, 0);
    // Toggle 11 -> 01 -> 11. The boundary edge sees 11.
    run_period(PER, 1000, 1,  100, 1, 700, 3, -1, 0);
    // Toggle 11 -> 01 -> 11 -> 01. The boundary edge sees 01.
    run_period(PER, 1000, 1,  100, 1, 700, 3, 1200, 1);
    largura_b = 2'b10;
    run_period(PER, 50, 1,    10, 0, -1, 0, -1, 0);
    largura_a = 2'b10;
    run_period(PER, 0, 1250,  -1, 0, -1, 0, -1, 0);
    // Partial period in the middle of the pulse, then reset asynchronously.
    run_period(201, 500, 1250, -1, 0, -1, 0, -1, 0);
    #4 reset = 1'b0;
    #1;
    check("mid reset pwm_a", pwm_a, 0);
    check("mid reset db_a", db_a, 0);
    check("mid reset pwm_b", pwm_b, 0);
    check("mid reset db_b", db_b, 0);
    check("mid reset cnt", 32'(dut_a.cnt), 0);
    check("mid reset largura_ativa", dut_a.largura_ativa, 0);
    step();
    check("mid reset hold pwm_b", pwm_b, 0);
    @(negedge clock);
    reset = 1'b1;
    k     = 0;
    run_period(PER, 0, 0,     -1, 0, -1, 0, -1, 0);
    run_period(PER, 500, 1250, -1, 0, -1, 0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
